// File: rtl/sequence_checker.sv
// -----------------------------------------------------------------------------
// sequence_checker
//
// Tracks an asymmetric periodic waveform on seq_in. One period is
// high T_H1 / low T_L1 / high T_H2 / low T_L2, and each run may deviate by
// +/-TOL cycles. After LOCK_N consecutive good periods the checker reports
// lock. Any deviation while tracking pulses err and drops back to hunting.
//
// State table
//   state  | meaning
//   HUNT   | waiting for a falling edge that closes a T_H1-long high run
//   L1     | measuring the short low run (T_L1), expecting a rise
//   H2     | measuring the short high run (T_H2), expecting a fall
//   L2     | measuring the long low run (T_L2), expecting a rise
//   H1     | measuring the long high run (T_H1), expecting a fall
//
// Ports
//   clock       in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   seq_in      in   monitored waveform, synchronous to clock
//   locked      out  at least LOCK_N consecutive good periods seen
//   err         out  one-cycle pulse per mismatch while tracking
//   period_cnt  out  good periods completed (wraps)
//   err_cnt     out  mismatches seen (saturates at 255)
// -----------------------------------------------------------------------------
module sequence_checker #(
    parameter int T_H1   = 12,
    parameter int T_L1   = 5,
    parameter int T_H2   = 3,
    parameter int T_L2   = 10,
    parameter int TOL    = 1,
    parameter int LOCK_N = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        seq_in,
    output logic        locked,
    output logic        err,
    output logic [15:0] period_cnt,
    output logic [7:0]  err_cnt
);

    localparam int GW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_N);

    typedef enum logic [2:0] {
        S_HUNT,
        S_L1,
        S_H2,
        S_L2,
        S_H1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_seq_s;
    logic            r_seq_p;
    logic [7:0]      r_run_len;
    logic [GW-1:0]   r_good_cnt;
    logic            r_locked;
    logic            r_err;
    logic [15:0]     r_period_cnt;
    logic [7:0]      r_err_cnt;

    logic            w_edge;
    logic            w_rise;
    logic            w_fall;
    logic            w_match;
    logic            w_timeout;
    logic            w_mis;
    logic            w_good;
    int              w_t_exp;

    assign w_edge = r_seq_s ^ r_seq_p;
    assign w_rise = w_edge & r_seq_s;
    assign w_fall = w_edge & ~r_seq_s;

    // Window check on a completed run; the lower bound clamps at zero.
    function automatic logic run_match(input logic [7:0] run, input int t);
        int r;
        int lo;
        int hi;
        r  = int'({24'd0, run});
        lo = (t > TOL) ? (t - TOL) : 0;
        hi = t + TOL;
        return (r >= lo) && (r <= hi);
    endfunction

    always_comb begin
        w_t_exp = T_H1;
        case (r_state)
            S_L1:    w_t_exp = T_L1;
            S_H2:    w_t_exp = T_H2;
            S_L2:    w_t_exp = T_L2;
            default: w_t_exp = T_H1;
        endcase
    end

    assign w_match = run_match(r_run_len, w_t_exp);

    // A run that has grown one past its window without an edge is already
    // wrong; flag it now rather than waiting for the edge. An edge in the
    // same cycle takes precedence, so the timeout is gated by !w_edge.
    assign w_timeout = (r_state != S_HUNT) && !w_edge &&
                       (int'({24'd0, r_run_len}) == (w_t_exp + TOL + 1));

    always_comb begin
        w_state_nxt = r_state;
        w_mis       = 1'b0;
        w_good      = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (w_fall && w_match) w_state_nxt = S_L1;
            end
            S_L1: begin
                if (w_edge) begin
                    if (w_rise && w_match) w_state_nxt = S_H2;
                    else                   w_mis = 1'b1;
                end else if (w_timeout) begin
                    w_mis = 1'b1;
                end
            end
            S_H2: begin
                if (w_edge) begin
                    if (w_fall && w_match) w_state_nxt = S_L2;
                    else                   w_mis = 1'b1;
                end else if (w_timeout) begin
                    w_mis = 1'b1;
                end
            end
            S_L2: begin
                if (w_edge) begin
                    if (w_rise && w_match) w_state_nxt = S_H1;
                    else                   w_mis = 1'b1;
                end else if (w_timeout) begin
                    w_mis = 1'b1;
                end
            end
            S_H1: begin
                if (w_edge) begin
                    if (w_fall && w_match) begin
                        w_state_nxt = S_L1;
                        w_good      = 1'b1;
                    end else begin
                        w_mis = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_mis = 1'b1;
                end
            end
            default: w_state_nxt = S_HUNT;
        endcase
        if (w_mis) w_state_nxt = S_HUNT;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_seq_s   <= 1'b0;
            r_seq_p   <= 1'b0;
            r_run_len <= 8'd0;
        end else begin
            r_seq_s <= seq_in;
            r_seq_p <= r_seq_s;
            if (w_edge)                  r_run_len <= 8'd1;
            else if (r_run_len != 8'hFF) r_run_len <= r_run_len + 8'd1;
        end
    end

    // locked follows good_cnt with one cycle of lag, so it rises the cycle
    // after the count reaches LOCK_N and falls the cycle after an err.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_good_cnt   <= '0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
            r_period_cnt <= 16'd0;
            r_err_cnt    <= 8'd0;
        end else begin
            r_err    <= w_mis;
            r_locked <= (r_good_cnt == LOCK_V);
            if (w_mis) begin
                r_good_cnt <= '0;
                if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end else if (w_good) begin
                r_period_cnt <= r_period_cnt + 16'd1;
                if (r_good_cnt != LOCK_V) r_good_cnt <= r_good_cnt + 1'b1;
            end
        end
    end

    assign locked     = r_locked;
    assign err        = r_err;
    assign period_cnt = r_period_cnt;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_sequence_checker.sv
module tb_sequence_checker;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        seq_in  = 1'b0;
    logic        locked;
    logic        err;
    logic [15:0] period_cnt;
    logic [7:0]  err_cnt;

    sequence_checker dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .seq_in     (seq_in),
        .locked     (locked),
        .err        (err),
        .period_cnt (period_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clock = ~clock;

    int total  = 0;
    int bad    = 0;
    int err_hi = 0;

    // Number of clock cycles err was seen high.
    always @(negedge clock) if (reset_n && err) err_hi++;

    typedef struct {
        bit lvl;
        int n;
        bit e_lock;
        int e_pcnt;
        int e_ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic run(input bit lvl, input int n);
        seq_in = lvl;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        seq_in  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_pcnt", int'(period_cnt), 0);
        chk("rst_ecnt", int'(err_cnt), 0);
        @(negedge clock);
        reset_n = 1'b1;
        run(1'b0, 4);
    endtask

    // Entry high run plus two full ideal periods; ends inside the L1 low run.
    task automatic two_periods();
        run(1, 12); run(0, 5); run(1, 3); run(0, 10);
        run(1, 12); run(0, 5); run(1, 3); run(0, 10);
        run(1, 12); run(0, 5);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int base;
        int at;

        // Checked after each run; a run's own end is evaluated only when the
        // following run starts.
        tbl.push_back('{1'b1, 12, 1'b0, 0, 0});
        tbl.push_back('{1'b0,  5, 1'b0, 0, 0});
        tbl.push_back('{1'b1,  3, 1'b0, 0, 0});
        tbl.push_back('{1'b0, 10, 1'b0, 0, 0});
        tbl.push_back('{1'b1, 12, 1'b0, 0, 0});
        tbl.push_back('{1'b0,  5, 1'b0, 1, 0});
        tbl.push_back('{1'b1,  3, 1'b0, 1, 0});
        tbl.push_back('{1'b0, 10, 1'b0, 1, 0});
        tbl.push_back('{1'b1, 12, 1'b0, 1, 0});
        tbl.push_back('{1'b0,  5, 1'b1, 2, 0});
        tbl.push_back('{1'b1,  3, 1'b1, 2, 0});
        tbl.push_back('{1'b0, 10, 1'b1, 2, 0});
        tbl.push_back('{1'b1, 12, 1'b1, 2, 0});
        tbl.push_back('{1'b0,  5, 1'b1, 3, 0});
        tbl.push_back('{1'b1,  3, 1'b1, 3, 0});
        tbl.push_back('{1'b0, 10, 1'b1, 3, 0});
        tbl.push_back('{1'b1, 12, 1'b1, 3, 0});
        tbl.push_back('{1'b0,  7, 1'b1, 4, 0});
        tbl.push_back('{1'b1, 12, 1'b0, 4, 1});
        tbl.push_back('{1'b0,  5, 1'b0, 4, 1});
        tbl.push_back('{1'b1,  3, 1'b0, 4, 1});
        tbl.push_back('{1'b0, 10, 1'b0, 4, 1});
        tbl.push_back('{1'b1, 12, 1'b0, 4, 1});
        tbl.push_back('{1'b0,  5, 1'b0, 5, 1});
        tbl.push_back('{1'b1,  3, 1'b0, 5, 1});
        tbl.push_back('{1'b0, 10, 1'b0, 5, 1});
        tbl.push_back('{1'b1, 12, 1'b0, 5, 1});
        tbl.push_back('{1'b0,  5, 1'b1, 6, 1});
        tbl.push_back('{1'b1,  3, 1'b1, 6, 1});
        tbl.push_back('{1'b0, 11, 1'b1, 6, 1});
        tbl.push_back('{1'b1, 13, 1'b1, 6, 1});
        tbl.push_back('{1'b0,  4, 1'b1, 7, 1});
        tbl.push_back('{1'b1,  3, 1'b1, 7, 1});
        tbl.push_back('{1'b0, 11, 1'b1, 7, 1});
        tbl.push_back('{1'b1, 13, 1'b1, 7, 1});
        tbl.push_back('{1'b0,  4, 1'b1, 8, 1});
        tbl.push_back('{1'b1,  2, 1'b1, 8, 1});
        tbl.push_back('{1'b0,  9, 1'b1, 8, 1});
        tbl.push_back('{1'b1, 11, 1'b1, 8, 1});
        tbl.push_back('{1'b0,  6, 1'b1, 9, 1});
        tbl.push_back('{1'b1,  3, 1'b1, 9, 1});
        tbl.push_back('{1'b0, 10, 1'b1, 9, 1});
        tbl.push_back('{1'b1, 14, 1'b1, 9, 1});
        tbl.push_back('{1'b0,  5, 1'b0, 9, 2});

        // Table: ideal lock, long L1 run, relock, tolerance edges, H1 too long.
        do_reset();
        base = err_hi;
        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i].lvl, tbl[i].n);
            chk($sformatf("v%0d_locked", i), int'(locked), int'(tbl[i].e_lock));
            chk($sformatf("v%0d_pcnt", i), int'(period_cnt), tbl[i].e_pcnt);
            chk($sformatf("v%0d_ecnt", i), int'(err_cnt), tbl[i].e_ecnt);
        end
        chk("tbl_err_cycles", err_hi - base, 2);

        // Stuck high in H2: single timeout pulse when run_len reaches 5.
        do_reset();
        two_periods();
        chk("to_pre_locked", int'(locked), 1);
        base = err_hi;
        at   = -1;
        seq_in = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (err && at < 0) at = i;
        end
        chk("to_err_cycle", at, 7);
        chk("to_err_cycles", err_hi - base, 1);
        chk("to_ecnt", int'(err_cnt), 1);
        chk("to_locked", int'(locked), 0);
        chk("to_pcnt", int'(period_cnt), 2);
        run(0, 5);
        chk("to_hunt_ecnt", int'(err_cnt), 1);
        chk("to_hunt_err_cycles", err_hi - base, 1);

        // Asynchronous reset in the middle of L2, then relock from zero.
        do_reset();
        two_periods();
        run(1, 3);
        run(0, 4);
        chk("ar_pre_locked", int'(locked), 1);
        chk("ar_pre_pcnt", int'(period_cnt), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_locked", int'(locked), 0);
        chk("ar_err", int'(err), 0);
        chk("ar_pcnt", int'(period_cnt), 0);
        chk("ar_ecnt", int'(err_cnt), 0);
        @(negedge clock);
        reset_n = 1'b1;
        run(0, 3);
        chk("ar_rel_pcnt", int'(period_cnt), 0);
        two_periods();
        chk("ar_relock", int'(locked), 1);
        chk("ar_re_pcnt", int'(period_cnt), 2);
        chk("ar_re_ecnt", int'(err_cnt), 0);

        // 257 L1 mismatches: err_cnt saturates, err keeps pulsing.
        do_reset();
        base = err_hi;
        for (int k = 0; k < 257; k++) begin
            run(1, 12);
            run(0, 2);
        end
        run(1, 12);
        chk("sat_ecnt", int'(err_cnt), 255);
        chk("sat_err_cycles", err_hi - base, 257);
        chk("sat_pcnt", int'(period_cnt), 0);
        chk("sat_locked", int'(locked), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequence_checker.md
SEQUENCE_CHECKER -- requirements
Module: sequence_checker

Interface
REQ-001 Parameter T_H1, default 12: expected long-high run, in clock cycles.
REQ-002 Parameter T_L1, default 5: expected short-low run, in clock cycles.
REQ-003 Parameter T_H2, default 3: expected short-high run, in clock cycles.
REQ-004 Parameter T_L2, default 10: expected long-low run, in clock cycles.
REQ-005 Parameter TOL, default 1: allowed +/- deviation per run, in cycles.
REQ-006 Parameter LOCK_N, default 2: consecutive good periods required to assert lock.
REQ-007 Port clock, input, 1 bit: the single clock; all flops rise-edge on it.
REQ-008 Port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 Port seq_in, input, 1 bit: monitored asymmetric waveform, synchronous to clock.
REQ-010 Port locked, output, 1 bit: pattern tracked for at least LOCK_N consecutive good periods.
REQ-011 Port err, output, 1 bit: one-cycle pulse on any mismatch while tracking.
REQ-012 Port period_cnt, output, 16 bits: count of good periods completed.
REQ-013 Port err_cnt, output, 8 bits: count of mismatches.

Function
REQ-014 seq_in registered once into seq_s; prior value kept in seq_p; edge = seq_s != seq_p; rise = edge & seq_s; fall = edge & !seq_s.
REQ-015 run_len is 8 bits: loads 1 on edge, else increments, saturating at 255; completed run = run_len value in the edge cycle, before reload.
REQ-016 Run "matches" segment T when T-TOL <= completed run <= T+TOL (unsigned; lower bound clamps at 0).
REQ-017 FSM states: HUNT, L1, H2, L2, H1.
REQ-018 HUNT: fall with matching T_H1 run -> L1; any other edge -> stay HUNT; no err in HUNT.
REQ-019 L1: rise with matching T_L1 run -> H2; H2: fall with matching T_H2 run -> L2; L2: rise with matching T_L2 run -> H1.
REQ-020 H1: fall with matching T_H1 run -> L1, period_cnt += 1 (wraps at 65535->0), good_cnt += 1 saturating at LOCK_N.
REQ-021 Mismatch in any non-HUNT state (edge with non-matching run, or run_len reaching expected+TOL+1 without an edge) -> err=1 for one cycle, err_cnt += 1 saturating at 255, good_cnt=0, locked=0, state -> HUNT.
REQ-022 Timeout mismatch fires exactly once per occurrence; HUNT then waits for the next fall.
REQ-023 locked asserts in the cycle after good_cnt reaches LOCK_N; deasserts the cycle after any err.
REQ-024 Detection latency: edge on seq_in -> state/err/counter update 2 clocks later (1 sample + 1 decision).
REQ-025 Edge and timeout in the same cycle: evaluate the edge; timeout is ignored.

Reset
REQ-026 reset_n low asynchronously forces: state=HUNT, seq_s=seq_p=0, run_len=0, good_cnt=0, locked=0, err=0, period_cnt=0, err_cnt=0.
REQ-027 Reset asserted mid-period discards partial runs; after release, the first fall is evaluated only against T_H1 from HUNT.
REQ-028 Deassertion synchronous to clock; no output changes on the first edge after release other than sampling seq_in.

Verification
REQ-029 Ideal waveform high12/low5/high3/low10 repeated 4 periods -> err never 1; locked=1 after the 2nd good period; period_cnt=3 at the end (first fall only enters L1).
REQ-030 Locked, then one low run of 7 instead of 5 -> single err pulse 2 clocks after the rise; err_cnt=1; locked=0; relock after 2 good periods.
REQ-031 Runs of 13/4/3/11 (within TOL=1) -> no err; locked=1.
REQ-032 Locked, seq_in held high 40 cycles in H2 -> err pulses once when run_len reaches 5; state=HUNT; err_cnt increments by exactly 1.
REQ-033 reset_n pulsed low mid-L2 -> all outputs 0 immediately; clean waveform afterward relocks with period_cnt restarting from 0.
REQ-034 Force err_cnt to 255 via 256 mismatches -> err_cnt stays 255; err still pulses.
